// File: rtl/misao_mem_pkg.sv
// ============================================================================
// misao_mem_pkg : shared widths and owner encoding for the misao memory arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package misao_mem_pkg;

  localparam int DEFAULT_ADDR_W = 15;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/misao_mem_rport.sv
// ============================================================================
// misao_mem_rport : per-master read-return register (rvalid pulse + held rdata)
// Revision: 1.0
// ============================================================================
`default_nettype none

module misao_mem_rport #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [DATA_W-1:0] din,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  // rdata is only loaded on a granted read so it holds until the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= capture;
      if (capture) begin
        rdata <= din;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/misao_mem_arbiter.sv
// ============================================================================
// misao_mem_arbiter : round-robin byte arbiter (core vs DMA) with ownership lock
// Revision: 1.0
// ============================================================================
`default_nettype none

module misao_mem_arbiter
  import misao_mem_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic              c_lock,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              c_gnt,
  output logic              d_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_enable_read,
  output logic              mem_enable_write,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              lock_err
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  owner_t           last,       last_nx;
  owner_t           lock_owner, owner_nx;
  logic [CNT_W-1:0] lock_cnt,   cnt_nx;
  logic             err_nx;
  logic             beat_lock;

  // Grant selection; rst is active-low, so no grant is possible while it is held
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      case (lock_owner)
        OWN_C:   c_gnt = c_req;
        OWN_D:   d_gnt = d_req;
        default: begin
          if (c_req && d_req) begin
            c_gnt = (last != OWN_C);
            d_gnt = (last == OWN_C);
          end else begin
            c_gnt = c_req;
            d_gnt = d_req;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_addr         = '0;
    mem_data_out     = '0;
    mem_enable_read  = 1'b0;
    mem_enable_write = 1'b0;
    beat_lock        = 1'b0;
    if (c_gnt) begin
      mem_addr         = c_addr;
      mem_data_out     = c_wdata;
      mem_enable_write = c_we;
      mem_enable_read  = ~c_we;
      beat_lock        = c_lock;
    end else if (d_gnt) begin
      mem_addr         = d_addr;
      mem_data_out     = d_wdata;
      mem_enable_write = d_we;
      mem_enable_read  = ~d_we;
      beat_lock        = d_lock;
    end
  end

  assign mem_rw = mem_enable_write;

  // An owner beat always wins over expiry: it restarts the idle count
  always_comb begin
    last_nx  = last;
    owner_nx = lock_owner;
    cnt_nx   = lock_cnt;
    err_nx   = 1'b0;
    if (c_gnt || d_gnt) begin
      last_nx  = c_gnt ? OWN_C : OWN_D;
      owner_nx = beat_lock ? (c_gnt ? OWN_C : OWN_D) : OWN_NONE;
      cnt_nx   = '0;
    end else if (lock_owner != OWN_NONE) begin
      if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
        owner_nx = OWN_NONE;
        cnt_nx   = '0;
        err_nx   = 1'b1;
      end else begin
        cnt_nx = lock_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last       <= OWN_D;
      lock_owner <= OWN_NONE;
      lock_cnt   <= '0;
      lock_err   <= 1'b0;
    end else begin
      last       <= last_nx;
      lock_owner <= owner_nx;
      lock_cnt   <= cnt_nx;
      lock_err   <= err_nx;
    end
  end

  misao_mem_rport #(.DATA_W(DATA_W)) u_c_rport (
    .clk     (clk),
    .rst     (rst),
    .capture (c_gnt & ~c_we),
    .din     (mem_data_in),
    .rvalid  (c_rvalid),
    .rdata   (c_rdata)
  );

  misao_mem_rport #(.DATA_W(DATA_W)) u_d_rport (
    .clk     (clk),
    .rst     (rst),
    .capture (d_gnt & ~d_we),
    .din     (mem_data_in),
    .rvalid  (d_rvalid),
    .rdata   (d_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_misao_mem_arbiter.sv
// ============================================================================
// tb_misao_mem_arbiter : directed scenarios plus randomized traffic against a
// behavioural arbiter/memory model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_misao_mem_arbiter;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 8;
  localparam int LOCK_MAX = 4;
  localparam int MEM_N    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic c_req, c_we, c_lock, d_req, d_we, d_lock;
  logic [ADDR_W-1:0] c_addr, d_addr;
  logic [DATA_W-1:0] c_wdata, d_wdata;
  logic c_gnt, d_gnt, c_rvalid, d_rvalid;
  logic [DATA_W-1:0] c_rdata, d_rdata;
  logic mem_enable_read, mem_enable_write, mem_rw, lock_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out, mem_data_in;

  logic [DATA_W-1:0] mem_arr   [0:MEM_N-1];
  logic [DATA_W-1:0] model_mem [0:MEM_N-1];

  int n_chk  = 0;
  int n_fail = 0;

  // model state: ports indexed 0 = core, 1 = DMA; owner -1 = none
  int                m_last;
  int                m_owner;
  int                m_idle;
  logic              m_rv [2];
  logic [DATA_W-1:0] m_rd [2];
  logic              m_err;

  always #5 clk = ~clk;

  misao_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .c_gnt(c_gnt), .d_gnt(d_gnt),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .lock_err(lock_err)
  );

  function automatic logic [DATA_W-1:0] init_byte(input int i);
    if (i == 'h80) return 8'h05;
    if (i == 'h81) return 8'hA7;
    return 8'((i * 37) ^ (i >> 7) ^ 8'h5A);
  endfunction

  assign mem_data_in = mem_arr[mem_addr];

  initial begin
    for (int i = 0; i < MEM_N; i++) mem_arr[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (mem_enable_write) mem_arr[mem_addr] <= mem_data_out;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_owner = -1;
    m_idle  = 0;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    m_rd[0] = '0;   m_rd[1] = '0;
    m_err   = 1'b0;
  endtask

  // Evaluate the arbitration rules for the current inputs, compare, then advance
  task automatic model_step();
    logic rq [2];
    logic wq [2];
    logic lk [2];
    logic [ADDR_W-1:0] aq [2];
    logic [DATA_W-1:0] dq [2];
    int g, p;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic er, ew;
    rq[0] = c_req;  rq[1] = d_req;
    wq[0] = c_we;   wq[1] = d_we;
    lk[0] = c_lock; lk[1] = d_lock;
    aq[0] = c_addr; aq[1] = d_addr;
    dq[0] = c_wdata; dq[1] = d_wdata;
    if (!rst) begin
      chk("rst c_gnt", c_gnt, 0);
      chk("rst d_gnt", d_gnt, 0);
      chk("rst rd strobe", mem_enable_read, 0);
      chk("rst wr strobe", mem_enable_write, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst c_rvalid", c_rvalid, 0);
      chk("rst d_rvalid", d_rvalid, 0);
      chk("rst c_rdata", c_rdata, 0);
      chk("rst d_rdata", d_rdata, 0);
      chk("rst lock_err", lock_err, 0);
      model_reset();
    end else begin
      g = -1;
      for (int k = 0; k < 2; k++) begin
        p = (k == 0) ? (1 - m_last) : m_last;
        if (g < 0 && rq[p] && (m_owner < 0 || m_owner == p)) g = p;
      end
      ea = '0; ed = '0; er = 1'b0; ew = 1'b0;
      if (g >= 0) begin
        ea = aq[g]; ed = dq[g]; ew = wq[g]; er = !wq[g];
      end
      chk("c_gnt", c_gnt, (g == 0));
      chk("d_gnt", d_gnt, (g == 1));
      chk("mem_enable_read", mem_enable_read, er);
      chk("mem_enable_write", mem_enable_write, ew);
      chk("mem_rw", mem_rw, ew);
      chk("mem_addr", mem_addr, ea);
      chk("mem_data_out", mem_data_out, ed);
      chk("c_rvalid", c_rvalid, m_rv[0]);
      chk("c_rdata", c_rdata, m_rd[0]);
      chk("d_rvalid", d_rvalid, m_rv[1]);
      chk("d_rdata", d_rdata, m_rd[1]);
      chk("lock_err", lock_err, m_err);
      m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_err = 1'b0;
      if (g >= 0) begin
        if (er) begin
          m_rv[g] = 1'b1;
          m_rd[g] = model_mem[ea];
        end else begin
          model_mem[ea] = ed;
        end
        m_last  = g;
        m_owner = lk[g] ? g : -1;
        m_idle  = 0;
      end else if (m_owner >= 0) begin
        m_idle++;
        if (m_idle == LOCK_MAX) begin
          m_owner = -1;
          m_idle  = 0;
          m_err   = 1'b1;
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_step();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_lock = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic set_c(input logic rq, input logic we, input logic lk,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    c_req = rq; c_we = we; c_lock = lk; c_addr = a; c_wdata = wd;
  endtask

  task automatic set_d(input logic rq, input logic we, input logic lk,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    d_req = rq; d_we = we; d_lock = lk; d_addr = a; d_wdata = wd;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    settle(); cycle_end();
    settle(); cycle_end();
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < MEM_N; i++) model_mem[i] = init_byte(i);
    model_reset();
    idle_inputs();
    settle();
    chk("reset lock_err", lock_err, 0);
    chk("reset c_rvalid", c_rvalid, 0);
    cycle_end();

    // single core read of 0x80
    rst = 1'b1;
    set_c(1, 0, 0, 15'h0080, 8'h00);
    settle();
    chk("t1 c_gnt", c_gnt, 1);
    chk("t1 read strobe", mem_enable_read, 1);
    chk("t1 mem_addr", mem_addr, 32'h80);
    cycle_end();
    idle_inputs();
    settle();
    chk("t1 c_rvalid", c_rvalid, 1);
    chk("t1 c_rdata", c_rdata, 32'h05);
    cycle_end();

    // contention after reset alternates starting with core
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_c(1, 0, 0, 15'h0010, 8'h00);
      set_d(1, 0, 0, 15'h0020, 8'h00);
      settle();
      chk("t2 c_gnt", c_gnt, (i % 2 == 0));
      chk("t2 d_gnt", d_gnt, (i % 2 == 1));
      cycle_end();
    end

    // locked two-byte write while DMA keeps requesting
    apply_reset();
    set_d(1, 0, 0, 15'h0040, 8'h00);
    set_c(1, 1, 1, 15'h0090, 8'h34);
    settle();
    chk("t3 beat1 c_gnt", c_gnt, 1);
    chk("t3 beat1 d_gnt", d_gnt, 0);
    cycle_end();
    set_c(1, 1, 0, 15'h0091, 8'h12);
    settle();
    chk("t3 beat2 c_gnt", c_gnt, 1);
    chk("t3 beat2 d_gnt", d_gnt, 0);
    cycle_end();
    set_c(0, 0, 0, 15'h0000, 8'h00);
    settle();
    chk("t3 third d_gnt", d_gnt, 1);
    chk("t3 mem 0x90", mem_arr[15'h0090], 32'h34);
    chk("t3 mem 0x91", mem_arr[15'h0091], 32'h12);
    chk("t3 model 0x90", model_mem[15'h0090], 32'h34);
    chk("t3 model 0x91", model_mem[15'h0091], 32'h12);
    cycle_end();

    // lock timeout: core locks then goes idle for LOCK_MAX cycles
    apply_reset();
    set_d(1, 0, 0, 15'h0041, 8'h00);
    set_c(1, 0, 1, 15'h0050, 8'h00);
    settle();
    chk("t4 lock beat c_gnt", c_gnt, 1);
    chk("t4 lock beat d_gnt", d_gnt, 0);
    cycle_end();
    set_c(0, 0, 0, 15'h0000, 8'h00);
    for (int i = 1; i <= LOCK_MAX; i++) begin
      settle();
      chk("t4 held d_gnt", d_gnt, 0);
      chk("t4 held lock_err", lock_err, 0);
      cycle_end();
    end
    settle();
    chk("t4 expiry lock_err", lock_err, 1);
    chk("t4 expiry d_gnt", d_gnt, 1);
    cycle_end();
    idle_inputs();
    settle();
    chk("t4 after lock_err", lock_err, 0);
    cycle_end();

    // DMA back-to-back reads
    set_d(1, 0, 0, 15'h0080, 8'h00);
    settle();
    chk("t5 beat1 d_gnt", d_gnt, 1);
    cycle_end();
    set_d(1, 0, 0, 15'h0081, 8'h00);
    settle();
    chk("t5 beat2 d_gnt", d_gnt, 1);
    chk("t5 rv1", d_rvalid, 1);
    chk("t5 rd1", d_rdata, 32'h05);
    cycle_end();
    idle_inputs();
    settle();
    chk("t5 rv2", d_rvalid, 1);
    chk("t5 rd2", d_rdata, 32'hA7);
    cycle_end();
    settle();
    chk("t5 rv end", d_rvalid, 0);
    cycle_end();

    // reset in the cycle after a locked core read
    set_c(1, 0, 1, 15'h0080, 8'h00);
    settle();
    chk("t6 c_gnt", c_gnt, 1);
    cycle_end();
    rst = 1'b0;
    settle();
    chk("t6 c_rvalid dropped", c_rvalid, 0);
    chk("t6 no strobe", mem_enable_read, 0);
    cycle_end();
    rst = 1'b1;
    idle_inputs();
    set_d(1, 0, 0, 15'h0022, 8'h00);
    settle();
    chk("t6 lock cleared d_gnt", d_gnt, 1);
    cycle_end();
    apply_reset();
    set_c(1, 0, 0, 15'h0011, 8'h00);
    set_d(1, 0, 0, 15'h0012, 8'h00);
    settle();
    chk("t6 tie c_gnt", c_gnt, 1);
    chk("t6 tie d_gnt", d_gnt, 0);
    cycle_end();

    // randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        settle(); cycle_end();
        if ($urandom_range(0, 1) == 1) begin
          settle(); cycle_end();
        end
        rst = 1'b1;
      end
      c_req   = ($urandom_range(0, 9) < 6);
      c_we    = ($urandom_range(0, 9) < 4);
      c_lock  = ($urandom_range(0, 9) < 3);
      c_addr  = ADDR_W'($urandom_range(0, 255));
      c_wdata = DATA_W'($urandom);
      d_req   = ($urandom_range(0, 9) < 6);
      d_we    = ($urandom_range(0, 9) < 4);
      d_lock  = ($urandom_range(0, 9) < 3);
      d_addr  = ADDR_W'($urandom_range(0, 255));
      d_wdata = DATA_W'($urandom);
      if ($urandom_range(0, 7) == 0) c_addr = ADDR_W'($urandom);
      if ($urandom_range(0, 7) == 0) d_addr = ADDR_W'($urandom);
      settle();
      cycle_end();
    end

    idle_inputs();
    settle(); cycle_end();
    settle(); cycle_end();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/misao_mem_arbiter.md
# misao_mem_arbiter

Two-port memory arbiter placed between the misao core memory port, a DMA/loader master and the single 8-bit program/data memory. It grants one byte access per cycle and uses round-robin priority on contention. A lock lets a master keep ownership for multi-byte transfers, such as the two-byte XMEM word accesses in LK16 mode. Read data is registered and returned one cycle after the grant.

## Interface
- ADDR_W, 15, byte address width (matches mem_addr)
- DATA_W, 8, data width
- LOCK_MAX, 4, idle cycles a lock may persist without a granted beat from its owner
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- c_req / d_req  in  1  core / DMA request, one byte per cycle
- c_we / d_we  in  1  1 = write, 0 = read
- c_lock / d_lock  in  1  hold ownership after this beat
- c_addr / d_addr  in  ADDR_W  byte address
- c_wdata / d_wdata  in  DATA_W  write data
- c_gnt / d_gnt  out  1  beat accepted this cycle (combinational)
- c_rvalid / d_rvalid  out  1  read data valid, one cycle after a granted read
- c_rdata / d_rdata  out  DATA_W  registered read data
- mem_enable_read  out  1  memory read strobe
- mem_enable_write  out  1  memory write strobe
- mem_rw  out  1  equals mem_enable_write
- mem_addr  out  ADDR_W  address of the granted master
- mem_data_out  out  DATA_W  write data of the granted master
- mem_data_in  in  DATA_W  memory read data, combinational in the strobe cycle
- lock_err  out  1  one-cycle pulse when a lock is force-released

## Operation
- Registered state:
  - `last`: last granted master (C or D).
  - `lock_owner`: NONE, C or D.
  - `lock_cnt`: width $clog2(LOCK_MAX+1).
  - Per port: rvalid and rdata registers.
  - lock_err register.
- Grant selection (combinational):
  - If lock_owner = X, only X may be granted. The other master sees gnt = 0 even if X is idle.
  - Otherwise, a single requester is granted.
  - If both request, the master that is not `last` is granted.
- Granted beat:
  - Drive mem_addr and mem_data_out from the granted master.
  - Assert mem_enable_write if we = 1; otherwise assert mem_enable_read.
  - With no grant, both strobes are 0. mem_addr and mem_data_out are 0.
- On every grant, `last` is updated to the granted master.
- Lock register update:
  - A granted beat with lock = 1 sets lock_owner to that master and clears lock_cnt.
  - A granted beat with lock = 0 sets lock_owner to NONE.
  - If there is no beat from the owner while locked, lock_cnt increments.
  - When lock_cnt reaches LOCK_MAX, lock_owner becomes NONE and lock_err pulses for one cycle. Arbitration is normal from the next cycle.
- Read return:
  - On a granted read, mem_data_in is captured into that port's rdata at the clock edge.
  - The port's rvalid is high for the following cycle.
  - rdata holds its value until the next read by that port.
- Writes produce no rvalid.

## Timing
- Reset values:
  - gnt, rvalid, rdata, mem_* outputs and lock_err: 0.
  - last = D, so C wins the first tie.
  - lock_owner = NONE.
  - lock_cnt = 0.
- Grant and memory strobe latency: 0 cycles from req.
- Read data latency: 1 cycle after grant. A master may issue back-to-back beats every cycle.
- Simultaneous events:
  - A lock and the expiry of an existing lock cannot occur in the same cycle, because only the owner can be granted while locked.
  - A granted beat from the owner in the expiry cycle counts as a beat: the counter clears and no error is raised.
- A request with req = 0 is ignored. The we, lock, addr and wdata inputs of a non-granted master are don't-care.
- Reset mid-transfer:
  - Any pending rvalid is dropped.
  - The lock is released.
  - No strobe is issued during reset.

## Structure
- Package misao_mem_pkg:
  - ADDR_W and DATA_W defaults.
  - Owner enum: OWN_NONE, OWN_C, OWN_D.
- A per-port read-return register is a natural sub-module: misao_mem_rport, holding rvalid and rdata capture, instantiated twice.
- The arbiter core and lock counter stay in the top module.

## Test plan
- Single master: core reads addr 0x0080 holding 0x05.
  - c_gnt = 1 in the same cycle with mem_enable_read = 1.
  - Next cycle: c_rvalid = 1, c_rdata = 0x05.
- Contention after reset: both request in the same cycle.
  - C is granted first, then D, then C, alternating while both hold req.
- Locked word write:
  - Core writes 0x34 @0x0090 with lock = 1, then 0x12 @0x0091 with lock = 0, while DMA requests continuously.
  - d_gnt = 0 for both beats.
  - Memory ends with [0x90] = 0x34 and [0x91] = 0x12.
  - DMA is granted in the third cycle.
- Lock timeout:
  - Core takes the lock, then drops req for LOCK_MAX cycles.
  - lock_err pulses for 1 cycle.
  - DMA is granted on the next cycle.
- Back-to-back reads: DMA reads 0x80 then 0x81 on consecutive cycles.
  - d_rvalid is high for 2 consecutive cycles with the correct data, one cycle behind the grants.
- Reset mid-read: assert rst in the cycle after a granted read.
  - c_rvalid = 0.
  - Lock is cleared.
  - First tie after reset goes to C.
